// File: rtl/id_ex_pipe_stage.sv
// Decode-to-execute pipeline register: DEPTH stages of {valid, data, ctrl} with
// flush > stall > advance priority and saturating hazard event counters.
module id_ex_pipe_stage #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              busy
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("id_ex_pipe_stage: DEPTH must be in 1..4");
        end
    endgenerate

    logic [DEPTH-1:0]  r_valid;
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [CTRL_W-1:0] r_ctrl [DEPTH];
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              w_stall_evt;

    assign w_stall_evt = stall_i & ~flush_i;

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its neighbour's pre-edge value; blocking here would collapse the shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the stage arrays are tiny flop banks, not RAM, so resetting the
            // payload too is cheap and makes every output read 0 during reset.
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
                r_ctrl[k] <= '0;
            end
        end else if (flush_i) begin
            // Payload is left as-is; only valid and ctrl define a bubble.
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_ctrl[k] <= '0;
            end
        end else if (!stall_i) begin
            r_valid[0] <= in_valid;
            r_data[0]  <= in_data;
            r_ctrl[0]  <= in_valid ? in_ctrl : '0;
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_data[k]  <= r_data[k-1];
                r_ctrl[k]  <= r_ctrl[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (flush_i && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];
    assign out_ctrl  = r_ctrl[DEPTH-1];
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign busy      = |r_valid;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Scoreboard bench: a DEPTH=2 instance with wide counters and a DEPTH=1 instance
// with 2-bit counters share stimulus; expected stage contents live in queues.
module tb_id_ex_pipe_stage;

    localparam int DEPTH_A = 2;
    localparam int MAX_A   = 65535;
    localparam int MAX_S   = 3;

    typedef struct {
        logic         v;
        logic [127:0] d;
        logic [15:0]  c;
    } ent_t;

    logic         clk;
    logic         rst_n;
    logic         stall_i;
    logic         flush_i;
    logic         in_valid;
    logic [127:0] in_data;
    logic [15:0]  in_ctrl;

    logic         out_valid;
    logic [127:0] out_data;
    logic [15:0]  out_ctrl;
    logic [15:0]  stall_cnt;
    logic [15:0]  flush_cnt;
    logic         busy;

    logic         s_out_valid;
    logic [127:0] s_out_data;
    logic [15:0]  s_out_ctrl;
    logic [1:0]   s_stall_cnt;
    logic [1:0]   s_flush_cnt;
    logic         s_busy;

    int total = 0;
    int bad   = 0;

    ent_t sb [$];
    ent_t sb_s [$];
    int   m_stall, m_flush, ms_stall, ms_flush;

    id_ex_pipe_stage #(.DATA_W(128), .CTRL_W(16), .DEPTH(DEPTH_A), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .busy(busy)
    );

    id_ex_pipe_stage #(.DATA_W(128), .CTRL_W(16), .DEPTH(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            assert (!$isunknown({stall_i, flush_i})) else begin
                bad++;
                $error("FAIL x_ctrl observed=%b expected=known", {stall_i, flush_i});
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    task automatic model_reset();
        ent_t z;
        z.v = 1'b0; z.d = '0; z.c = '0;
        sb.delete();
        sb_s.delete();
        for (int i = 0; i < DEPTH_A; i++) sb.push_back(z);
        sb_s.push_back(z);
        m_stall = 0; m_flush = 0; ms_stall = 0; ms_flush = 0;
    endtask

    task automatic compare_all();
        logic b;
        b = 1'b0;
        foreach (sb[i]) b = b | sb[i].v;
        check("out_valid", 128'(out_valid), 128'(sb[0].v));
        check("out_data",  out_data,        sb[0].d);
        check("out_ctrl",  128'(out_ctrl),  128'(sb[0].c));
        check("busy",      128'(busy),      128'(b));
        check("stall_cnt", 128'(stall_cnt), 128'(m_stall));
        check("flush_cnt", 128'(flush_cnt), 128'(m_flush));
        check("s_out_valid", 128'(s_out_valid), 128'(sb_s[0].v));
        check("s_out_ctrl",  128'(s_out_ctrl),  128'(sb_s[0].c));
        check("s_busy",      128'(s_busy),      128'(sb_s[0].v));
        check("s_stall_cnt", 128'(s_stall_cnt), 128'(ms_stall));
        check("s_flush_cnt", 128'(s_flush_cnt), 128'(ms_flush));
    endtask

    // Drive one cycle of stimulus, update the expected stage contents, compare.
    task automatic step(input logic st, input logic fl, input logic v,
                        input logic [127:0] d, input logic [15:0] c);
        ent_t n;
        stall_i  = st;
        flush_i  = fl;
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
        @(posedge clk);
        #1;
        if (fl) begin
            foreach (sb[i]) begin sb[i].v = 1'b0; sb[i].c = '0; end
            foreach (sb_s[i]) begin sb_s[i].v = 1'b0; sb_s[i].c = '0; end
            m_flush  = sat_inc(m_flush, MAX_A);
            ms_flush = sat_inc(ms_flush, MAX_S);
        end else if (st) begin
            m_stall  = sat_inc(m_stall, MAX_A);
            ms_stall = sat_inc(ms_stall, MAX_S);
        end else begin
            n.v = v;
            n.d = d;
            n.c = v ? c : 16'h0;
            sb.push_back(n);
            void'(sb.pop_front());
            sb_s.push_back(n);
            void'(sb_s.pop_front());
        end
        compare_all();
    endtask

    initial begin
        rst_n    = 1'b0;
        stall_i  = 1'b0;
        flush_i  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_ctrl  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Passthrough: latency of exactly DEPTH edges, busy from the first edge.
        step(0, 0, 1, 128'hA5, 16'h0013);
        check("pt_busy_e1",  128'(busy), 128'd1);
        check("pt_valid_e1", 128'(out_valid), 128'd0);
        step(0, 0, 0, 128'h0, 16'h0);
        check("pt_data_e2",  out_data, 128'hA5);
        check("pt_ctrl_e2",  128'(out_ctrl), 128'h0013);
        check("pt_valid_e2", 128'(out_valid), 128'd1);

        // Stall: 0x11 sits at the output while 0x22 is offered and ignored.
        step(0, 0, 1, 128'h11, 16'h0011);
        step(0, 0, 0, 128'h0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 128'h22, 16'h0022);
            check("stall_hold_data", out_data, 128'h11);
        end
        check("stall_cnt_3", 128'(stall_cnt), 128'd3);
        step(0, 0, 1, 128'h22, 16'h0022);
        check("stall_rel_e1", out_data, 128'h0);
        step(0, 0, 0, 128'h0, 16'h0);
        check("stall_rel_e2", out_data, 128'h22);

        // Flush beats a simultaneous stall; the offered 0x55 never emerges.
        step(0, 0, 1, 128'h33, 16'h0033);
        step(0, 0, 1, 128'h44, 16'h0044);
        step(1, 1, 1, 128'h55, 16'h0055);
        check("fl_valid", 128'(out_valid), 128'd0);
        check("fl_ctrl",  128'(out_ctrl), 128'd0);
        check("fl_busy",  128'(busy), 128'd0);
        check("fl_stall_cnt", 128'(stall_cnt), 128'd3);
        check("fl_flush_cnt", 128'(flush_cnt), 128'd1);
        for (int i = 0; i < DEPTH_A + 1; i++) begin
            step(0, 0, 0, 128'h0, 16'h0);
            check("fl_no_emerge", 128'(out_valid), 128'd0);
        end

        // Bubble: ctrl is masked, payload still travels.
        step(0, 0, 0, 128'hBEEF, 16'hFFFF);
        step(0, 0, 0, 128'h0, 16'h0);
        check("bub_valid", 128'(out_valid), 128'd0);
        check("bub_ctrl",  128'(out_ctrl), 128'h0);
        check("bub_data",  out_data, 128'hBEEF);

        // Asynchronous reset mid-cycle with valid entries in flight.
        step(0, 0, 1, 128'h66, 16'h0066);
        step(1, 0, 1, 128'h77, 16'h0077);
        step(0, 0, 1, 128'h77, 16'h0077);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_valid", 128'(out_valid), 128'd0);
        check("rst_async_data",  out_data, 128'd0);
        check("rst_async_busy",  128'(busy), 128'd0);
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Saturation on the 2-bit counters.
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 1, 128'h88, 16'h0088);
            check("sat_stall", 128'(s_stall_cnt), 128'((i < 3) ? i + 1 : 3));
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 128'h99, 16'h0099);
            check("sat_flush", 128'(s_flush_cnt), 128'((i < 3) ? i + 1 : 3));
        end
        step(0, 0, 1, 128'hAA, 16'h00AA);
        check("s_data_after", s_out_data, 128'hAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
